refill_arbiter: RTL and testbench

Miss-refill controller sharing the single external memory read port between the instruction cache (fetch-stage miss, `f_cmiss`) and the data cache (memory-stage miss, `m_cmiss`). It grants one miss at a time, issues a line-aligned burst read, and steers returned beats to the owning cache. It pulses the matching `f_arrival`/`m_arrival` back to the hazard unit when the line is complete. It sits between the two caches and the bus interface, alongside the hazard unit.

---
 rtl/cache_pkg.sv | 18 +
 rtl/refill_arbiter.sv | 151 +++++++++++++++
 tb/tb_refill_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Definitions shared by the I/D caches and the refill arbiter:
// FSM state codes, cache owner ids and the line-offset width helper.
package cache_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Number of address bits that select a byte inside one cache line.
  function automatic int lineOffsetW(input int beats, input int dataW);
    return $clog2(beats) + $clog2(dataW / 8);
  endfunction

endpackage

// File: rtl/refill_arbiter.sv
// Shares the external memory read port between I-cache and D-cache line refills:
// grants one miss at a time, issues a line burst and steers the beats to the owner.
module refill_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     f_cmiss,
  input  logic [ADDR_W-1:0]        f_addr,
  input  logic                     m_cmiss,
  input  logic [ADDR_W-1:0]        m_addr,
  output logic                     bus_req,
  output logic [ADDR_W-1:0]        bus_addr,
  input  logic                     bus_ack,
  input  logic                     bus_rvalid,
  input  logic [DATA_W-1:0]        bus_rdata,
  input  logic                     bus_err,
  output logic                     rf_valid,
  output logic                     rf_sel,
  output logic [$clog2(BEATS)-1:0] rf_beat,
  output logic [DATA_W-1:0]        rf_data,
  output logic                     f_arrival,
  output logic                     m_arrival,
  output logic                     refill_err,
  output logic                     busy
);

  localparam int                CNT_W     = $clog2(BEATS);
  localparam int                OFF_W     = lineOffsetW(BEATS, DATA_W);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  logic [1:0]        r_state;
  logic              r_owner;
  logic              r_afterDone;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busReq;
  logic [ADDR_W-1:0] r_busAddr;
  logic              r_rfValid;
  logic              r_rfSel;
  logic [CNT_W-1:0]  r_rfBeat;
  logic [DATA_W-1:0] r_rfData;
  logic              r_fArrival;
  logic              r_mArrival;
  logic              r_refillErr;
  logic              r_busy;

  logic w_grantD;
  logic w_grantI;
  logic w_lastBeat;

  // The requester served by the refill that just finished may still show its stale
  // miss level in the first IDLE cycle; only the other requester can win there.
  assign w_grantD   = m_cmiss && !(r_afterDone && (r_owner == OWN_D));
  assign w_grantI   = f_cmiss && !(r_afterDone && (r_owner == OWN_I));
  assign w_lastBeat = (r_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_I;
      r_afterDone <= 1'b0;
      r_cnt       <= '0;
      r_busReq    <= 1'b0;
      r_busAddr   <= '0;
      r_rfValid   <= 1'b0;
      r_rfSel     <= 1'b0;
      r_rfBeat    <= '0;
      r_rfData    <= '0;
      r_fArrival  <= 1'b0;
      r_mArrival  <= 1'b0;
      r_refillErr <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rfValid   <= 1'b0;
      r_fArrival  <= 1'b0;
      r_mArrival  <= 1'b0;
      r_refillErr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_afterDone <= 1'b0;
          // The D-side miss belongs to the older instruction, so it wins ties.
          if (w_grantD) begin
            r_owner   <= OWN_D;
            r_busAddr <= m_addr & LINE_MASK;
            r_busReq  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_ADDR;
          end else if (w_grantI) begin
            r_owner   <= OWN_I;
            r_busAddr <= f_addr & LINE_MASK;
            r_busReq  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus_ack) begin
            r_busReq <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus_rvalid) begin
            // An errored beat is dropped and the rest of the line is abandoned.
            if (bus_err) begin
              r_refillErr <= 1'b1;
              r_fArrival  <= (r_owner == OWN_I);
              r_mArrival  <= (r_owner == OWN_D);
              r_state     <= ST_DONE;
            end else begin
              r_rfValid <= 1'b1;
              r_rfSel   <= r_owner;
              r_rfBeat  <= r_cnt;
              r_rfData  <= bus_rdata;
              r_cnt     <= r_cnt + CNT_W'(1);
              if (w_lastBeat) begin
                r_fArrival <= (r_owner == OWN_I);
                r_mArrival <= (r_owner == OWN_D);
                r_state    <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          r_busy      <= 1'b0;
          r_afterDone <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_req    = r_busReq;
  assign bus_addr   = r_busAddr;
  assign rf_valid   = r_rfValid;
  assign rf_sel     = r_rfSel;
  assign rf_beat    = r_rfBeat;
  assign rf_data    = r_rfData;
  assign f_arrival  = r_fArrival;
  assign m_arrival  = r_mArrival;
  assign refill_err = r_refillErr;
  assign busy       = r_busy;

endmodule

// File: tb/tb_refill_arbiter.sv
// Randomized scoreboard bench for refill_arbiter: a timeline model schedules every
// burst, beat and arrival; a negedge monitor pops and compares what the DUT shows.
module tb_refill_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BEATS      = 4;
  localparam int LINE_BYTES = BEATS * DATA_W / 8;

  typedef struct packed {
    logic             owner;
    logic [31:0]      addr;
    logic [3:0]       ackDelay;
    logic [3:0][3:0]  gaps;
    logic [3:0][31:0] data;
    logic [2:0]       errBeat;
  } plan_t;

  typedef struct packed {
    logic [31:0] addr;
    int          cycle;
  } expBurst_t;

  typedef struct packed {
    logic        sel;
    logic [1:0]  beat;
    logic [31:0] data;
    int          cycle;
  } expBeat_t;

  typedef struct packed {
    logic owner;
    logic err;
    int   cycle;
  } expArr_t;

  logic              clk;
  logic              rstn;
  logic              f_cmiss;
  logic [ADDR_W-1:0] f_addr;
  logic              m_cmiss;
  logic [ADDR_W-1:0] m_addr;
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ack;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;
  logic              rf_valid;
  logic              rf_sel;
  logic [1:0]        rf_beat;
  logic [DATA_W-1:0] rf_data;
  logic              f_arrival;
  logic              m_arrival;
  logic              refill_err;
  logic              busy;

  refill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk(clk), .rstn(rstn),
    .f_cmiss(f_cmiss), .f_addr(f_addr), .m_cmiss(m_cmiss), .m_addr(m_addr),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .rf_valid(rf_valid), .rf_sel(rf_sel), .rf_beat(rf_beat), .rf_data(rf_data),
    .f_arrival(f_arrival), .m_arrival(m_arrival), .refill_err(refill_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int assertCount = 0;
  int failCount   = 0;

  plan_t     plans[$];
  expBurst_t expBursts[$];
  expBeat_t  expBeats[$];
  expArr_t   expArrs[$];

  function automatic void checkOutput(input string name, input logic [63:0] actual,
                                      input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endfunction

  function automatic plan_t mkPlan(input logic owner, input logic [31:0] addr,
                                   input logic [3:0] ack, input logic [3:0][3:0] gaps,
                                   input logic [2:0] errBeat);
    plan_t p;
    p.owner    = owner;
    p.addr     = addr;
    p.ackDelay = ack;
    p.gaps     = gaps;
    p.errBeat  = errBeat;
    for (int i = 0; i < BEATS; i++) p.data[i] = $urandom;
    return p;
  endfunction

  function automatic plan_t randPlan(input logic owner);
    logic [3:0][3:0] g;
    logic [2:0]      e;
    g = '0;
    if ($urandom_range(0, 1) == 1)
      for (int i = 0; i < BEATS; i++) g[i] = 4'($urandom_range(0, 2));
    e = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3)) : 3'd4;
    return mkPlan(owner, $urandom, 4'($urandom_range(0, 3)), g, e);
  endfunction

  // Timeline of one refill whose bus_req first shows in cycle reqCycle.
  function automatic void planRefill(input plan_t p, input int reqCycle, output int arrCycle);
    int t;
    expBeat_t eb;
    expArr_t  ea;
    expBurst_t bu;
    bu.addr  = 32'((p.addr / LINE_BYTES) * LINE_BYTES);
    bu.cycle = reqCycle;
    expBursts.push_back(bu);
    t = reqCycle + 1 + int'(p.ackDelay);
    arrCycle = -1;
    for (int i = 0; i < BEATS; i++) begin
      t += int'(p.gaps[i]);
      if (int'(p.errBeat) == i) begin
        arrCycle = t + 1;
        break;
      end
      eb.sel   = p.owner;
      eb.beat  = 2'(i);
      eb.data  = p.data[i];
      eb.cycle = t + 1;
      expBeats.push_back(eb);
      if (i == BEATS - 1) arrCycle = t + 1;
      t++;
    end
    ea.owner = p.owner;
    ea.err   = (p.errBeat < 3'd4);
    ea.cycle = arrCycle;
    expArrs.push_back(ea);
    plans.push_back(p);
  endfunction

  // Memory slave: replays the queued plans, with junk rvalid while the request waits.
  int    sPhase = 0;
  plan_t sPlan;
  int    ackLeft, beatIdx, gapLeft;
  always @(negedge clk) begin
    bus_ack    = 1'b0;
    bus_rvalid = 1'b0;
    bus_err    = 1'b0;
    bus_rdata  = $urandom;
    if (!rstn) begin
      sPhase = 0;
    end else begin
      if (sPhase == 2) begin
        if (gapLeft > 0) begin
          gapLeft--;
        end else begin
          bus_rvalid = 1'b1;
          bus_rdata  = sPlan.data[beatIdx];
          bus_err    = (int'(sPlan.errBeat) == beatIdx);
          if (bus_err || beatIdx == BEATS - 1) begin
            sPhase = 0;
          end else begin
            beatIdx++;
            gapLeft = int'(sPlan.gaps[beatIdx]);
          end
        end
      end else if (sPhase == 0 && bus_req) begin
        if (plans.size() == 0) begin
          sPlan = '0;
          sPlan.errBeat = 3'd4;
        end else begin
          sPlan = plans.pop_front();
        end
        ackLeft = int'(sPlan.ackDelay);
        sPhase  = 1;
      end
      if (sPhase == 1) begin
        if (ackLeft == 0) begin
          bus_ack = 1'b1;
          sPhase  = 2;
          beatIdx = 0;
          gapLeft = int'(sPlan.gaps[0]);
        end else begin
          ackLeft--;
          bus_rvalid = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: every DUT event must match the head of its expectation queue.
  logic        prevReq   = 1'b0;
  logic        holdValid = 1'b0;
  logic [31:0] holdAddr;
  always @(negedge clk) begin
    expBurst_t bu;
    expBeat_t  eb;
    expArr_t   ea;
    if (!rstn) begin
      prevReq   = 1'b0;
      holdValid = 1'b0;
    end else begin
      if (bus_req && !prevReq) begin
        if (expBursts.size() == 0) begin
          checkOutput("unexpected bus_req", 64'(bus_req), 64'(0));
        end else begin
          bu = expBursts.pop_front();
          checkOutput("bus_req cycle", 64'(cyc), 64'(bu.cycle));
          holdAddr  = bu.addr;
          holdValid = 1'b1;
        end
      end
      if (bus_req && holdValid) checkOutput("bus_addr", 64'(bus_addr), 64'(holdAddr));
      if (!bus_req) holdValid = 1'b0;
      prevReq = bus_req;
      if (rf_valid) begin
        if (expBeats.size() == 0) begin
          checkOutput("unexpected rf_valid", 64'(rf_valid), 64'(0));
        end else begin
          eb = expBeats.pop_front();
          checkOutput("rf sel/beat/data", 64'({rf_sel, rf_beat, rf_data}),
                      64'({eb.sel, eb.beat, eb.data}));
          checkOutput("rf_valid cycle", 64'(cyc), 64'(eb.cycle));
        end
      end
      if (f_arrival || m_arrival) begin
        if (expArrs.size() == 0) begin
          checkOutput("unexpected arrival", 64'({f_arrival, m_arrival}), 64'(0));
        end else begin
          ea = expArrs.pop_front();
          checkOutput("arrival f/m/err", 64'({f_arrival, m_arrival, refill_err}),
                      64'({~ea.owner, ea.owner, ea.err}));
          checkOutput("arrival cycle", 64'(cyc), 64'(ea.cycle));
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " control outputs"},
                64'({bus_req, rf_valid, f_arrival, m_arrival, refill_err, busy, rf_sel}), 64'(0));
    checkOutput({tag, " rf_beat/rf_data"}, 64'({rf_beat, rf_data}), 64'(0));
    checkOutput({tag, " bus_addr"}, 64'(bus_addr), 64'(0));
  endtask

  // Raises the requested misses in one cycle; each requester holds its level through
  // the IDLE cycle after its arrival so a stale re-grant would be visible.
  task automatic applyStimulus(input logic doD, input logic doI, input plan_t pD,
                               input plan_t pI, input logic fPulse);
    int c, arrD, arrI, dropD, dropI;
    logic doneD, doneI;
    @(negedge clk);
    c    = cyc;
    arrD = -1;
    if (doD) begin
      planRefill(pD, c + 1, arrD);
      m_addr  = pD.addr;
      m_cmiss = 1'b1;
    end
    if (doI) begin
      planRefill(pI, doD ? arrD + 2 : c + 1, arrI);
      f_addr  = pI.addr;
      f_cmiss = 1'b1;
    end
    doneD = !doD;
    doneI = !doI;
    dropD = 0;
    dropI = 0;
    for (int n = 0; n < 300 && !(doneD && doneI); n++) begin
      @(negedge clk);
      if (dropD > 0) begin
        dropD--;
        if (dropD == 0) begin m_cmiss = 1'b0; doneD = 1'b1; end
      end
      if (dropI > 0) begin
        dropI--;
        if (dropI == 0) begin f_cmiss = 1'b0; doneI = 1'b1; end
      end
      if (doD && !doneD && dropD == 0 && m_arrival) dropD = 2;
      if (doI && !doneI && dropI == 0 && f_arrival) dropI = 2;
      if (fPulse && cyc == c + 3) begin f_addr = $urandom; f_cmiss = 1'b1; end
      if (fPulse && cyc == c + 4) f_cmiss = 1'b0;
    end
    checkOutput("refill within cycle budget", 64'({doneD, doneI}), 64'(3));
    m_cmiss = 1'b0;
    f_cmiss = 1'b0;
    @(negedge clk);
    checkOutput("busy low after refill", 64'(busy), 64'(0));
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  plan_t none;
  initial begin
    int    c, dummy;
    plan_t p;
    none = mkPlan(1'b0, 32'h0, 4'd0, '0, 3'd4);
    rstn = 1'b1; f_cmiss = 1'b0; m_cmiss = 1'b0; f_addr = '0; m_addr = '0;
    bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    #1 rstn = 1'b0;
    #3 checkAllZero("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    applyStimulus(1'b1, 1'b0, mkPlan(1'b1, 32'h1234, 4'd0, '0, 3'd4), none, 1'b0);
    applyStimulus(1'b1, 1'b1, mkPlan(1'b1, $urandom, 4'd0, '0, 3'd4),
                  mkPlan(1'b0, $urandom, 4'd0, '0, 3'd4), 1'b0);
    applyStimulus(1'b0, 1'b1, none, mkPlan(1'b0, $urandom, 4'd3, 16'h0110, 3'd4), 1'b0);
    applyStimulus(1'b1, 1'b0, mkPlan(1'b1, $urandom, 4'd0, '0, 3'd2), none, 1'b0);
    applyStimulus(1'b0, 1'b1, none, mkPlan(1'b0, $urandom, 4'd0, '0, 3'd4), 1'b0);

    // Reset during the second data beat of a D refill.
    @(negedge clk);
    c = cyc;
    p = mkPlan(1'b1, $urandom, 4'd0, '0, 3'd4);
    planRefill(p, c + 1, dummy);
    m_addr  = p.addr;
    m_cmiss = 1'b1;
    repeat (3) @(negedge clk);
    #3 rstn = 1'b0;
    m_cmiss = 1'b0;
    #1 checkAllZero("mid-burst reset");
    expBeats.delete();
    expArrs.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    applyStimulus(1'b1, 1'b0, randPlan(1'b1), none, 1'b0);

    applyStimulus(1'b1, 1'b0, mkPlan(1'b1, $urandom, 4'd0, '0, 3'd4), none, 1'b1);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       applyStimulus(1'b1, 1'b0, randPlan(1'b1), none, 1'b0);
        1:       applyStimulus(1'b0, 1'b1, none, randPlan(1'b0), 1'b0);
        2:       applyStimulus(1'b1, 1'b1, randPlan(1'b1), randPlan(1'b0), 1'b0);
        default: applyStimulus(1'b1, 1'b0, randPlan(1'b1), none, 1'b1);
      endcase
    end

    repeat (5) @(negedge clk);
    checkOutput("bursts left unseen", 64'(expBursts.size()), 64'(0));
    checkOutput("beats left unseen", 64'(expBeats.size()), 64'(0));
    checkOutput("arrivals left unseen", 64'(expArrs.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
